// File: rtl/toeplitz_ctrl_pkg.sv
// Shared types and helpers for the Toeplitz extractor sequencing controller.
// Used by toeplitz_ctrl and toeplitz_obuf.
package toeplitz_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    STREAM
  } state_t;

  function automatic int beats(input int n, input int width);
    return n / width;
  endfunction

endpackage

// File: rtl/toeplitz_ctrl_obuf.sv
// L-bit result holding register with valid/ready handshake, sticky overflow
// and a one-cycle drop pulse for results that arrive while the holder is full.
module toeplitz_obuf
  import toeplitz_pkg::*;
#(
  parameter int L = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [L-1:0] d,
  input  logic         strobe,
  output logic [L-1:0] q,
  output logic         valid,
  input  logic         ready,
  output logic         overflow,
  output logic         drop
);

  logic [L-1:0] q_p1;
  logic         vld_p1;
  logic         ovf;
  logic         take;
  logic         load;

  // A strobe is accepted when the holder is empty or being drained this cycle.
  assign take = vld_p1 && ready;
  assign load = strobe && (!vld_p1 || ready);
  assign drop = strobe && vld_p1 && !ready;

  // Capture stage: ext_q -> q_p1.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_p1   <= '0;
      vld_p1 <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (load) begin
        q_p1   <= d;
        vld_p1 <= 1'b1;
      end else if (take) begin
        vld_p1 <= 1'b0;
      end
      if (drop) ovf <= 1'b1;
    end
  end

  assign q        = q_p1;
  assign valid    = vld_p1;
  assign overflow = ovf;

endmodule

// File: rtl/toeplitz_ctrl.sv
// Sequencer around the parallel Toeplitz extractor: ping-pong block fill,
// gap-free beat streaming with restart pulses, and result capture.
// Optional statistics counters are enabled by defining TOEPLITZ_CTRL_STATS_EN.
module toeplitz_ctrl
  import toeplitz_pkg::*;
#(
  parameter int N     = 256,
  parameter int L     = 128,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ext_reset,
  output logic [WIDTH-1:0] ext_data,
  input  logic [L-1:0]     ext_q,
  input  logic             ext_qstrobe,
  output logic [L-1:0]     out_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int BEATS = beats(N, WIDTH);
  localparam int FW    = $clog2(BEATS + 1);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(N);
  localparam logic [FW-1:0] FILL_FULL = FW'(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t           state, state_next;
  logic [N-1:0]     fill_buf;
  logic [N-1:0]     shreg;
  logic [FW-1:0]    fill_cnt;
  logic [FW-1:0]    wr_idx;
  logic [AW-1:0]    wr_base;
  logic [BW-1:0]    beat_cnt;
  logic             full;
  logic             accept;
  logic             copy;
  logic             blk_start;
  logic             sync_c;
  logic [WIDTH-1:0] data_c;
  logic             drop;

  assign full     = (fill_cnt == FILL_FULL);
  assign in_ready = !reset && (fill_cnt < FILL_FULL);
  assign accept   = in_valid && in_ready;

  // A copy frees the fill buffer, so a same-cycle beat restarts at the MSBs.
  assign wr_idx  = copy ? '0 : fill_cnt;
  assign wr_base = AW'(N - 1 - int'(wr_idx) * WIDTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt <= '0;
      fill_buf <= '0;
    end else begin
      fill_cnt <= wr_idx + FW'(accept);
      if (accept) fill_buf[wr_base -: WIDTH] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    copy       = 1'b0;
    blk_start  = 1'b0;
    sync_c     = 1'b0;
    data_c     = '0;
    case (state)
      IDLE: begin
        if (full) begin
          copy       = 1'b1;
          state_next = SYNC;
        end
      end
      SYNC: begin
        sync_c     = 1'b1;
        blk_start  = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        data_c = shreg[N-1 -: WIDTH];
        if (beat_cnt == LAST_BEAT) begin
          if (full) begin
            copy      = 1'b1;
            blk_start = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stream stage: shreg holds the block being replayed MSB-first.
  always_ff @(posedge clk) begin
    if (copy)                 shreg <= fill_buf;
    else if (state == STREAM) shreg <= shreg << WIDTH;
  end

  always_ff @(posedge clk) begin
    if (reset)                                          beat_cnt <= '0;
    else if (state != STREAM || beat_cnt == LAST_BEAT)  beat_cnt <= '0;
    else                                                beat_cnt <= beat_cnt + 1'b1;
  end

  assign ext_reset = reset || sync_c;
  assign ext_data  = reset ? '0 : data_c;
  assign busy      = (state != IDLE);

  toeplitz_obuf #(
    .L(L)
  ) u_obuf (
    .clk      (clk),
    .reset    (reset),
    .d        (ext_q),
    .strobe   (ext_qstrobe),
    .q        (out_q),
    .valid    (out_valid),
    .ready    (out_ready),
    .overflow (overflow),
    .drop     (drop)
  );

`ifdef TOEPLITZ_CTRL_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0] blk_q;
  logic [CNT_W-1:0] drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q  <= '0;
      drop_q <= '0;
    end else begin
      if (blk_start) blk_q  <= sat_inc(blk_q);
      if (drop)      drop_q <= sat_inc(drop_q);
    end
  end

  assign blk_cnt  = blk_q;
  assign drop_cnt = drop_q;
`else
  logic stats_unused;
  assign stats_unused = blk_start | drop;
  assign blk_cnt      = '0;
  assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_toeplitz_ctrl.sv
// Scoreboard bench for toeplitz_ctrl: the extractor beat stream must replay the
// accepted input beats in order, and results follow a one-deep holding model.
module tb_toeplitz_ctrl;

  localparam int N     = 256;
  localparam int L     = 128;
  localparam int W     = 4;
  localparam int BEATS = N / W;
`ifdef TOEPLITZ_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [L-1:0] val;
    int           cyc;
  } res_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b1;
  logic          in_ready;
  logic          ext_reset;
  logic [W-1:0]  ext_data;
  logic [L-1:0]  ext_q = '0;
  logic          ext_qstrobe = 1'b0;
  logic [L-1:0]  out_q;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overflow;
  logic          busy;
  logic [31:0]   blk_cnt;
  logic [31:0]   drop_cnt;

  logic [W-1:0]  beat_q[$];
  res_t          res_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            pulses = 0;
  int            stream_pops = 0;
  int            acc_since_rst = 0;
  int            exp_drops = 0;
  bit            exp_ovf = 1'b0;
  bit            rst_prev = 1'b0;

  toeplitz_ctrl #(.N(N), .L(L), .WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ext_reset  (ext_reset),
    .ext_data   (ext_data),
    .ext_q      (ext_q),
    .ext_qstrobe(ext_qstrobe),
    .out_q      (out_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .busy       (busy),
    .blk_cnt    (blk_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %s", name, what);
  endtask

  // Monitor: compares every DUT output cycle against the scoreboards.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ext_reset", ext_reset, 1);
      chk("rst_ext_data", ext_data, 0);
      if (rst_prev) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_out_q", out_q, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
      end
    end else begin
      if (busy && !ext_reset) begin
        if (beat_q.size() == 0) fail_evt("stream_extra", "beat with no accepted input pending");
        else chk("stream_beat", ext_data, beat_q.pop_front());
        stream_pops++;
      end else begin
        chk("quiet_ext_data", ext_data, 0);
      end
      if (ext_reset) pulses++;
      if (out_valid) begin
        if (res_q.size() == 0) fail_evt("out_spurious", "out_valid with no result expected");
        else begin
          chk("out_q", out_q, res_q[0].val);
          if (out_ready) void'(res_q.pop_front());
        end
      end else if (res_q.size() != 0 && res_q[0].cyc < cyc) begin
        fail_evt("out_valid_missing", "out_valid=0 with a result held");
      end
    end
    rst_prev = reset;
  end

  task automatic send_beat(input logic [W-1:0] d, output int tries);
    bit done;
    done  = 1'b0;
    tries = 0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      tries++;
      if (in_ready) begin
        beat_q.push_back(d);
        acc_since_rst++;
        done = 1'b1;
      end else if (tries > 300) begin
        fail_evt("send_timeout", "in_ready stuck low");
        done = 1'b1;
      end
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    int g;
    done = 1'b0;
    g    = 0;
    repeat (3) @(negedge clk);
    while (!done) begin
      @(negedge clk);
      #3;
      g++;
      if (!busy) done = 1'b1;
      else if (g > 400) begin
        fail_evt("idle_timeout", "busy never dropped");
        done = 1'b1;
      end
    end
  endtask

  task automatic out_cycle(input bit s, input logic [L-1:0] q, input bit rdy);
    res_t r;
    @(negedge clk);
    ext_qstrobe = s;
    ext_q       = q;
    out_ready   = rdy;
    #1;
    if (s && !reset) begin
      if (res_q.size() == 0 || rdy) begin
        r.val = q;
        r.cyc = cyc;
        res_q.push_back(r);
      end else begin
        exp_ovf = 1'b1;
        exp_drops++;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset       = 1'b1;
    in_valid    = 1'b0;
    ext_qstrobe = 1'b0;
    out_ready   = 1'b0;
    beat_q.delete();
    res_q.delete();
    exp_ovf       = 1'b0;
    exp_drops     = 0;
    acc_since_rst = 0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [L-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int t;
    int stalls;
    int p0;
    int base;
    int g;
    logic [L-1:0] h;
    logic [L-1:0] x;
    logic [L-1:0] a5;
    h  = 128'h0123456789ABCDEF0123456789ABCDEF;
    a5 = {16{8'hA5}};

    // Reset held three cycles with in_valid asserted.
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #2;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_ext_reset", ext_reset, 0);

    // Single block from idle: check SYNC placement and stream length.
    for (int k = 0; k < BEATS; k++) send_beat(W'(k % 16), t);
    idle_in();
    #2;
    chk("idle_full_no_sync", ext_reset, 0);
    chk("idle_full_busy", busy, 0);
    @(negedge clk); #2;
    chk("sync_pulse", ext_reset, 1);
    chk("sync_busy", busy, 1);
    @(negedge clk); #2;
    chk("first_beat_no_sync", ext_reset, 0);
    chk("first_beat_busy", busy, 1);
    repeat (BEATS - 1) @(negedge clk);
    #2;
    chk("busy_last_beat", busy, 1);
    @(negedge clk); #2;
    chk("busy_drop", busy, 0);
    chk("single_pulses", pulses, 1);
    chk("single_drained", beat_q.size(), 0);

    // Back-to-back: two blocks, only the first gets a restart pulse.
    p0     = pulses;
    stalls = 0;
    for (int k = 0; k < 2 * BEATS; k++) begin
      send_beat(W'($urandom), t);
      stalls += t - 1;
    end
    idle_in();
    wait_idle();
    chk("b2b_stalls", stalls, 1);
    chk("b2b_pulses", pulses - p0, 1);
    chk("b2b_drained", beat_q.size(), 0);

    // Result capture and overflow on a second unconsumed strobe.
    out_cycle(1'b1, h, 1'b0);
    out_cycle(1'b0, '0, 1'b0);
    chk("cap_valid", out_valid, 1);
    chk("cap_q", out_q, h);
    out_cycle(1'b1, '1, 1'b0);
    out_cycle(1'b0, '0, 1'b0);
    chk("ovf_q_kept", out_q, h);
    chk("ovf_set", overflow, 1);
    chk("ovf_drop_cnt", drop_cnt, STATS ? 1 : 0);

    // Simultaneous consume and strobe after clearing the sticky flag.
    do_reset(2);
    #2;
    chk("ovf_cleared", overflow, 0);
    x = rand128();
    out_cycle(1'b1, x, 1'b0);
    out_cycle(1'b1, a5, 1'b1);
    out_cycle(1'b0, '0, 1'b0);
    chk("simul_valid", out_valid, 1);
    chk("simul_q", out_q, a5);
    chk("simul_no_ovf", overflow, 0);
    out_cycle(1'b0, '0, 1'b1);
    out_cycle(1'b0, '0, 1'b0);
    chk("consumed_valid", out_valid, 0);
    chk("consumed_q_held", out_q, a5);

    // Reset in mid-stream with a partial next block already filling.
    for (int k = 0; k < BEATS + 10; k++) send_beat(W'($urandom), t);
    idle_in();
    base = stream_pops;
    g    = 0;
    while (stream_pops < base + 31 && g < 400) begin
      @(negedge clk); #3;
      g++;
    end
    if (g >= 400) fail_evt("midstream_timeout", "stream never reached beat 30");
    do_reset(1);
    #2;
    chk("mid_rst_ext_data", ext_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_blk_cnt", blk_cnt, 0);
    p0 = pulses;
    for (int k = 0; k < BEATS; k++) send_beat(W'($urandom), t);
    idle_in();
    wait_idle();
    chk("restart_pulse", pulses - p0, 1);
    chk("restart_drained", beat_q.size(), 0);

    // Randomised traffic on both sides at once.
    fork
      begin
        for (int k = 0; k < 5 * BEATS; k++) begin
          int gap;
          gap = $urandom_range(0, 2);
          for (int j = 0; j < gap; j++) idle_in();
          send_beat(W'($urandom), t);
        end
        idle_in();
      end
      begin
        for (int k = 0; k < 600; k++)
          out_cycle($urandom_range(0, 3) == 0, rand128(), 1'($urandom_range(0, 1)));
      end
    join
    wait_idle();
    repeat (3) out_cycle(1'b0, '0, 1'b1);
    out_cycle(1'b0, '0, 1'b0);
    chk("rand_beats_drained", beat_q.size(), 0);
    chk("rand_results_drained", res_q.size(), 0);
    chk("rand_out_valid", out_valid, 0);
    chk("rand_overflow", overflow, exp_ovf);
    chk("rand_drop_cnt", drop_cnt, STATS ? exp_drops : 0);
    chk("rand_blk_cnt", blk_cnt, STATS ? acc_since_rst / BEATS : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/toeplitz_ctrl.md
Name: toeplitz_ctrl

Overview:
- Sequencing controller placed in front of and behind the parallel Toeplitz extractor (toeplitz_p).
- Accepts raw entropy over a valid/ready stream and buffers one full N-bit block. It then streams that block into the extractor as N/WIDTH back-to-back WIDTH-bit beats, with a ping-pong fill buffer so consecutive blocks run gap-free.
- Issues an extractor restart pulse whenever a gap occurs between blocks.
- Captures each L-bit extractor result on qstrobe into a holding register with valid/ready output and overflow detection.

Parameters:
- N, 256, raw block size in bits; must be a multiple of WIDTH.
- L, 128, extracted output size in bits.
- WIDTH, 4, bits per beat on input stream and extractor data port.
- BEATS, N/WIDTH, beats per block (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  raw entropy beat.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller accepts beat this cycle.
- ext_reset  out  1  reset pulse to extractor.
- ext_data  out  WIDTH  beat to extractor data port.
- ext_q  in  L  extractor result.
- ext_qstrobe  in  1  extractor result valid (1-cycle pulse).
- out_q  out  L  held result.
- out_valid  out  1  out_q valid.
- out_ready  in  1  consumer takes out_q.
- overflow  out  1  sticky: a result was dropped.
- busy  out  1  engine in SYNC or STREAM.
- blk_cnt  out  32  blocks streamed (see optional feature).
- drop_cnt  out  32  results dropped (see optional feature).

Behaviour:
- Reset (synchronous, active-high):
  - in_ready=0 during reset; out_valid=0, out_q=0, overflow=0, busy=0, ext_data=0, ext_reset=1, counters=0.
  - The fill buffer and fill_cnt are cleared, and state goes to IDLE.
  - Reset mid-block discards partial fill and in-flight stream. ext_reset is high in every reset cycle.
- Fill buffer:
  - fill_cnt runs 0..BEATS, and in_ready = (fill_cnt < BEATS).
  - A beat is accepted when in_valid && in_ready. Beat k (k=0 first) is written to buf[N-1-k*WIDTH -: WIDTH], so the first beat lands in the MSBs.
  - full = (fill_cnt == BEATS).
- Stream engine FSM with states IDLE, SYNC, STREAM:
  - IDLE: ext_data=0, ext_reset=0. If full: copy buf into shreg, clear fill_cnt, go to SYNC.
  - SYNC: exactly one cycle with ext_reset=1 and ext_data=0, then go to STREAM with beat_cnt=0.
  - STREAM: ext_data = shreg[N-1 -: WIDTH]; shreg shifts left by WIDTH each cycle; beat_cnt increments.
  - On beat BEATS-1, if full: reload shreg, clear fill_cnt, and stay in STREAM with beat_cnt=0 (back-to-back, no ext_reset). Otherwise go to IDLE.
  - A beat accepted in the same cycle as a copy starts the new block: fill_cnt becomes 1 and the beat goes to the MSBs.
  - busy = (state != IDLE).
- Latency:
  - From the accept of the final input beat to the first ext_data beat is 3 cycles when idle: full registers, then IDLE→SYNC, then SYNC→STREAM.
  - Each block occupies exactly BEATS stream cycles.
- Output register:
  - On ext_qstrobe with out_valid==0, or with out_valid && out_ready: out_q<=ext_q, out_valid<=1.
  - On ext_qstrobe with out_valid && !out_ready: new result dropped, out_q unchanged, overflow<=1 (sticky until reset).
  - With no strobe, out_valid && out_ready clears out_valid.
  - out_q holds its last value after consumption.
- ext_qstrobe arriving in IDLE is still captured; the controller does not gate on extractor latency.

Optional Feature:
- Macro TOEPLITZ_CTRL_STATS_EN.
- Defined: blk_cnt increments on every SYNC→STREAM or STREAM→STREAM reload (i.e., per block start). drop_cnt increments on every dropped result. Both are 32-bit and saturate at 2^32-1.
- Undefined: blk_cnt and drop_cnt are tied to 0 and no counter registers are synthesized.

Decomposition:
- Package toeplitz_pkg holds:
  - the state enum typedef (IDLE, SYNC, STREAM);
  - function beats(N, WIDTH);
  - localparam CNT_W=32.
- One sub-module: toeplitz_obuf (L-bit holding register with valid/ready, overflow and drop pulse), instantiated once.

Test Plan (N=256, WIDTH=4, L=128):
- Reset: hold reset 3 cycles with in_valid=1 → in_ready=0, ext_reset=1, out_valid=0; after release in_ready=1, ext_reset=0.
- Single block: feed 64 beats 0x0..0xF repeating → SYNC cycle with ext_reset=1 occurs 2 cycles after the last accept; ext_data then replays 0,1,...,F ×4 over 64 consecutive cycles; busy drops the cycle after beat 63.
- Back-to-back: feed 128 beats continuously with in_valid=1 → second block follows beat 63 directly (beat_cnt wraps, no second ext_reset); in_ready deasserts only when buffer full while streaming.
- Output capture: ext_qstrobe with ext_q=128'h0123…CDEF and out_ready=0 → out_valid=1, out_q matches; a second strobe with ext_q=all-ones → out_q unchanged, overflow=1, drop_cnt=1 (STATS_EN).
- Simultaneous consume and strobe: out_valid=1, out_ready=1, strobe ext_q=128'hA5…A5 → out_valid stays 1, out_q=A5…A5, overflow remains 0.
- Reset mid-stream: assert reset at beat 30 → ext_data=0 and fill cleared next cycle; a fresh 64-beat block restarts with a SYNC pulse.
